// File: rtl/mac_tile_sequencer.sv
// mac_tile_sequencer: sequences one matrix-tile operation on the systolic MAC array.
// Accepts a tile command, optionally clears the accumulator, streams k_len operand
// rows from the input/weight buffers, waits out the array skew, then writes
// ARR_SIZE accumulated rows to the output buffer.
//
// Timing: the edge that samples start moves the FSM into LAUNCH (cycle 0). Every
// output is registered together with the state it belongs to, so the first
// command-visible activity (acc_reset, or the first read) appears in cycle 1.
module mac_tile_sequencer #(
    parameter int unsigned ARR_SIZE  = 4,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned KLEN_W    = 8,
    parameter int unsigned OP_ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    inp_base,
    input  logic [ADDR_W-1:0]    wt_base,
    input  logic [KLEN_W-1:0]    k_len,
    input  logic [OP_ADDR_W-1:0] op_base,
    input  logic                 accumulate,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 inp_rd_en,
    output logic [ADDR_W-1:0]    inp_rd_addr,
    output logic                 wt_rd_en,
    output logic [ADDR_W-1:0]    wt_rd_addr,
    output logic                 mac_valid,
    output logic                 acc_reset,
    output logic                 acc_wr,
    output logic [OP_ADDR_W-1:0] acc_op_addr
);

    localparam int unsigned DRAIN_LEN = 2 * ARR_SIZE - 1;
    localparam int unsigned DCNT_W    = $clog2(DRAIN_LEN + 1);
    localparam int unsigned RCNT_W    = $clog2(ARR_SIZE + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        CLEAR,
        FEED,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t                 state;
    logic [ADDR_W-1:0]      inp_base_q;
    logic [ADDR_W-1:0]      wt_base_q;
    logic [KLEN_W-1:0]      k_len_q;
    logic [OP_ADDR_W-1:0]   op_base_q;
    logic                   accumulate_q;
    logic [KLEN_W-1:0]      kcnt;
    logic [DCNT_W-1:0]      dcnt;
    logic [RCNT_W-1:0]      rcnt;
    logic                   err_pend;

    // Sequencer FSM, command latches, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            inp_base_q   <= '0;
            wt_base_q    <= '0;
            k_len_q      <= '0;
            op_base_q    <= '0;
            accumulate_q <= 1'b0;
            kcnt         <= '0;
            dcnt         <= '0;
            rcnt         <= '0;
            err_pend     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            inp_rd_en    <= 1'b0;
            inp_rd_addr  <= '0;
            wt_rd_en     <= 1'b0;
            wt_rd_addr   <= '0;
            mac_valid    <= 1'b0;
            acc_reset    <= 1'b0;
            acc_wr       <= 1'b0;
            acc_op_addr  <= '0;
        end else begin
            // Strobes default low; addresses hold their last value.
            done      <= 1'b0;
            err       <= 1'b0;
            acc_reset <= 1'b0;
            acc_wr    <= 1'b0;
            inp_rd_en <= 1'b0;
            wt_rd_en  <= 1'b0;
            // Buffer read latency is one cycle.
            mac_valid <= inp_rd_en;

            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (err_pend) begin
                        err      <= 1'b1;
                        done     <= 1'b1;
                        err_pend <= 1'b0;
                    end
                    if (start) begin
                        if (k_len == '0) begin
                            err_pend <= 1'b1;
                        end else begin
                            inp_base_q   <= inp_base;
                            wt_base_q    <= wt_base;
                            k_len_q      <= k_len;
                            op_base_q    <= op_base;
                            accumulate_q <= accumulate;
                            state        <= LAUNCH;
                        end
                    end
                end

                LAUNCH: begin
                    busy <= 1'b1;
                    if (!accumulate_q) begin
                        acc_reset <= 1'b1;
                        state     <= CLEAR;
                    end else begin
                        inp_rd_en   <= 1'b1;
                        wt_rd_en    <= 1'b1;
                        inp_rd_addr <= inp_base_q;
                        wt_rd_addr  <= wt_base_q;
                        kcnt        <= KLEN_W'(1);
                        state       <= FEED;
                    end
                end

                CLEAR: begin
                    inp_rd_en   <= 1'b1;
                    wt_rd_en    <= 1'b1;
                    inp_rd_addr <= inp_base_q;
                    wt_rd_addr  <= wt_base_q;
                    kcnt        <= KLEN_W'(1);
                    state       <= FEED;
                end

                FEED: begin
                    if (kcnt == k_len_q) begin
                        dcnt  <= DCNT_W'(1);
                        state <= DRAIN;
                    end else begin
                        inp_rd_en   <= 1'b1;
                        wt_rd_en    <= 1'b1;
                        inp_rd_addr <= inp_base_q + ADDR_W'(kcnt);
                        wt_rd_addr  <= wt_base_q + ADDR_W'(kcnt);
                        kcnt        <= kcnt + KLEN_W'(1);
                    end
                end

                DRAIN: begin
                    if (dcnt == DCNT_W'(DRAIN_LEN)) begin
                        acc_wr      <= 1'b1;
                        acc_op_addr <= op_base_q;
                        rcnt        <= RCNT_W'(1);
                        state       <= WRITE;
                    end else begin
                        dcnt <= dcnt + DCNT_W'(1);
                    end
                end

                WRITE: begin
                    if (rcnt == RCNT_W'(ARR_SIZE)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        acc_wr      <= 1'b1;
                        acc_op_addr <= op_base_q + OP_ADDR_W'(rcnt);
                        rcnt        <= rcnt + RCNT_W'(1);
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mac_tile_sequencer.md
Name: mac_tile_sequencer

Overview:
Sequences one matrix-tile operation on the systolic MAC array. On a start command it clears or keeps the accumulator and streams K operand rows from the input and weight buffers into the array. It then waits out the array skew and writes ARR_SIZE accumulated results into the output buffer. It sits between the instruction controller (command side) and the buffers/MAC/accumulator (datapath side).

Parameters:
ARR_SIZE, 4, systolic array dimension (rows = columns)
ADDR_W, 15, input/weight buffer address width
KLEN_W, 8, width of reduction-length field
OP_ADDR_W, 4, output buffer address width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  command strobe; sampled only in IDLE
inp_base  input  ADDR_W  first input-buffer address of tile
wt_base  input  ADDR_W  first weight-buffer address of tile
k_len  input  KLEN_W  reduction length (number of operand rows)
op_base  input  OP_ADDR_W  first output-buffer address for results
accumulate  input  1  1 = keep accumulator contents; 0 = clear before feed
busy  output  1  high from the cycle after an accepted start until DONE completes
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse: start with k_len==0
inp_rd_en  output  1  input buffer read enable
inp_rd_addr  output  ADDR_W  input buffer read address
wt_rd_en  output  1  weight buffer read enable
wt_rd_addr  output  ADDR_W  weight buffer read address
mac_valid  output  1  operand data on buffer outputs is valid for the array
acc_reset  output  1  clear accumulator (one cycle)
acc_wr  output  1  accumulator row to output buffer write strobe
acc_op_addr  output  OP_ADDR_W  output buffer address for acc_wr

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0; reset mid-operation aborts with no done pulse, and a start held during reset is ignored.
- Cycle n = n-th clock edge after the edge that samples start.
- IDLE: busy=0. start=1 with k_len==0 -> err=1 and done=1 for cycle 1, stay IDLE, no buffer reads. start=1 with k_len>0 -> latch inp_base, wt_base, k_len, op_base, accumulate; go to CLEAR if accumulate=0, else FEED.
- Parameters are latched; input changes while busy have no effect. start while busy is ignored (not queued).
- CLEAR: 1 cycle, acc_reset=1 -> FEED.
- FEED: k_len cycles; inp_rd_en=wt_rd_en=1; addresses = base + kcnt, kcnt = 0..k_len-1, modulo 2^ADDR_W (wrap at top of buffer). Last cycle -> DRAIN.
- mac_valid = read enable delayed one cycle (buffer read latency is 1).
- DRAIN: 2*ARR_SIZE-1 cycles, no reads -> WRITE. The first DRAIN cycle carries mac_valid for the last row.
- WRITE: ARR_SIZE cycles; acc_wr=1; acc_op_addr = op_base + row, row = 0..ARR_SIZE-1, modulo 2^OP_ADDR_W (wraps).
- DONE: 1 cycle, done=1, busy=0 -> IDLE. A start sampled in the DONE cycle is ignored; earliest accepted start is the next cycle.
- Latency with ARR_SIZE=A and clear: done in cycle 2+k+(2A-1)+A. Without clear, subtract 1.
- When inactive, addresses hold their last value; enables and strobes are 0.

Test Plan:
- reset; start, k_len=8, accumulate=0, inp_base=0x10, wt_base=0x200, op_base=2 -> acc_reset cycle 1; rd_en cycles 2..9 with inp addr 0x10..0x17 and wt addr 0x200..0x207; mac_valid cycles 3..10; acc_wr cycles 17..20 with addr 2..5; done cycle 21 only.
- Same command, accumulate=1 -> no acc_reset; reads cycles 1..8; done cycle 20.
- k_len=0 -> err=1 and done=1 in cycle 1, no rd_en, busy stays 0.
- inp_base=0x7FFE, k_len=4, op_base=14 -> inp addrs 0x7FFE,0x7FFF,0x0000,0x0001; acc_op_addr 14,15,0,1.
- Second start pulse during FEED and during DONE -> ignored; exactly one done pulse.
- reset asserted in cycle 5 of a k_len=8 op -> all outputs 0 next cycle, IDLE, no done; a new start afterwards completes normally.
